// File: rtl/prog_clk_div_pkg.sv
// Shared definitions for the programmable clock divider / PWM block:
// default geometry, the counter type and config validation helpers.
package prog_clk_div_pkg;

  localparam int W_DEF       = 27;
  localparam int DEF_DIV_DEF = 555555;

  typedef logic [W_DEF-1:0] cnt_t;

  // A period shorter than two cycles cannot hold both a high and a low phase.
  function automatic logic div_valid(input logic [63:0] div);
    return div >= 64'd2;
  endfunction

  // High time longer than the period saturates to a constant-high output.
  function automatic logic [63:0] clamp_high(input logic [63:0] div,
                                             input logic [63:0] high);
    return (high > div) ? div : high;
  endfunction

endpackage

// File: rtl/prog_clk_div_ch.sv
// One divider/PWM channel: period counter, active and shadow configuration,
// and the pending flag that defers a new configuration to a period boundary.
// Optional phase alignment input is present when PROG_CLK_DIV_SYNC_EN is defined.
module prog_clk_div_ch
  import prog_clk_div_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int DEF_DIV  = DEF_DIV_DEF,
  parameter int DEF_HIGH = DEF_DIV / 2
) (
  input  logic         clock_in,
  input  logic         reset_n,
  input  logic         en,
`ifdef PROG_CLK_DIV_SYNC_EN
  input  logic         sync_all,
`endif
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  input  logic [W-1:0] wr_high,
  output logic         clk_out,
  output logic         tick
);

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] DIV_RST  = W'(DEF_DIV);
  localparam logic [W-1:0] HIGH_RST = W'(DEF_HIGH);

  logic [W-1:0] cnt;
  logic [W-1:0] div_a;
  logic [W-1:0] high_a;
  logic [W-1:0] div_s;
  logic [W-1:0] high_s;
  logic         pend;
  logic         boundary;
  logic         apply;

  // Period end (or forced alignment) and when the shadow may be promoted.
  always_comb begin
`ifdef PROG_CLK_DIV_SYNC_EN
    boundary = en && (sync_all || (cnt >= div_a - ONE));
`else
    boundary = en && (cnt >= div_a - ONE);
`endif
    apply = pend && (boundary || !en);
  end

  // Counter, period-start tick and registered waveform output.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else begin
      if (!en || boundary) cnt <= '0;
      else                 cnt <= cnt + ONE;
      tick    <= boundary;
      clk_out <= en && (cnt < high_a);
    end
  end

  // Active configuration only changes between periods.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      div_a  <= DIV_RST;
      high_a <= HIGH_RST;
    end else if (apply) begin
      div_a  <= div_s;
      high_a <= high_s;
    end
  end

  // Shadow capture; a write in the same cycle as a promotion keeps pend set.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      div_s  <= DIV_RST;
      high_s <= HIGH_RST;
      pend   <= 1'b0;
    end else if (wr) begin
      div_s  <= wr_div;
      high_s <= wr_high;
      pend   <= 1'b1;
    end else if (apply) begin
      pend   <= 1'b0;
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider / PWM generator.
// Decodes and validates config writes, returns ack/err, and instantiates
// CH independent channels. Define PROG_CLK_DIV_SYNC_EN to add the sync_all
// phase-alignment input.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int CH       = 2,
  parameter int W        = W_DEF,
  parameter int DEF_DIV  = DEF_DIV_DEF,
  parameter int DEF_HIGH = DEF_DIV / 2,
  localparam int CHW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clock_in,
  input  logic           reset_n,
  input  logic [CH-1:0]  en,
`ifdef PROG_CLK_DIV_SYNC_EN
  input  logic           sync_all,
`endif
  input  logic           cfg_wr,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic [W-1:0]   cfg_high,
  output logic           cfg_ack,
  output logic           cfg_err,
  output logic [CH-1:0]  clk_out,
  output logic [CH-1:0]  tick
);

  logic          wr_ok;
  logic [W-1:0]  high_clamped;
  logic [CH-1:0] ch_wr;

  // Validate the write and steer it to exactly one channel.
  always_comb begin
    wr_ok        = cfg_wr && (int'(cfg_ch) < CH) && div_valid(64'(cfg_div));
    high_clamped = W'(clamp_high(64'(cfg_div), 64'(cfg_high)));
    ch_wr        = '0;
    for (int i = 0; i < CH; i++) begin
      ch_wr[i] = wr_ok && (int'(cfg_ch) == i);
    end
  end

  // One-cycle accept/reject response to every write strobe.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_ack <= wr_ok;
      cfg_err <= cfg_wr && !wr_ok;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    prog_clk_div_ch #(
      .W        (W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_ch (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .en       (en[g]),
`ifdef PROG_CLK_DIV_SYNC_EN
      .sync_all (sync_all),
`endif
      .wr       (ch_wr[g]),
      .wr_div   (cfg_div),
      .wr_high  (high_clamped),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
    );
  end

endmodule
